// File: rtl/flog_pack.sv
// flog_pack: packs a fixed-point log2 (unbiased exponent + fraction) into
// a bfloat16 result, handling NaN/-inf/+inf specials on capture.
// Ports:
//   clk, rst (sync, active-low)
//   valid_i, exp_i, frac_i, is_nan_i, is_inf_i, is_zero_i, is_neg_i (request)
//   result_o, valid_o (one-cycle pulse), busy_o (state != IDLE)
module flog_pack #(
    parameter int FRAC_W = 16,
    parameter int INT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [7:0]        exp_i,
    input  logic [FRAC_W-1:0] frac_i,
    input  logic              is_nan_i,
    input  logic              is_inf_i,
    input  logic              is_zero_i,
    input  logic              is_neg_i,
    output logic [15:0]       result_o,
    output logic              valid_o,
    output logic              busy_o
);

    localparam int WW = INT_W + FRAC_W;
    localparam int CW = $clog2(WW);

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [WW-1:0]   r_m;
    logic            r_s;
    logic [CW-1:0]   r_cnt;
    logic [15:0]     r_result;

    logic            w_special;
    logic [15:0]     w_spec_val;
    logic [INT_W-1:0] w_int;
    logic [WW-1:0]   w_w;
    logic [WW-1:0]   w_mag;
    logic            w_mag_zero;

    logic [6:0]      w_mant;
    logic            w_guard;
    logic            w_sticky;
    logic            w_rup;
    logic [7:0]      w_sum;
    logic [7:0]      w_exp;
    logic [7:0]      w_exp_f;

    // Special-case classification, in priority order
    always_comb begin
        w_special  = 1'b0;
        w_spec_val = 16'h0000;
        if (is_nan_i || (is_neg_i && !is_zero_i)) begin
            w_special  = 1'b1;
            w_spec_val = 16'h7FC0;
        end else if (is_zero_i || exp_i == 8'd0) begin
            w_special  = 1'b1;
            w_spec_val = 16'hFF80;
        end else if (is_inf_i || exp_i == 8'd255) begin
            w_special  = 1'b1;
            w_spec_val = 16'h7F80;
        end
    end

    // Signed fixed-point log value and its magnitude
    always_comb begin
        w_int      = exp_i - 8'd127;
        w_w        = {w_int, frac_i};
        w_mag      = w_w[WW-1] ? (~w_w + WW'(1)) : w_w;
        w_mag_zero = (w_mag == '0);
    end

    // Round-to-nearest-even on the normalised magnitude; a carry out of
    // the 7-bit mantissa leaves it zero and bumps the exponent
    always_comb begin
        w_mant   = r_m[WW-2:WW-8];
        w_guard  = r_m[WW-9];
        w_sticky = |r_m[WW-10:0];
        w_rup    = w_guard & (w_sticky | w_mant[0]);
        w_sum    = {1'b0, w_mant} + 8'(w_rup);
        w_exp    = 8'(127 + INT_W - 1) - 8'(r_cnt);
        w_exp_f  = w_exp + 8'(w_sum[7]);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (valid_i) begin
                    if (w_special || w_mag_zero) begin
                        w_next = DONE;
                    end else begin
                        w_next = NORM;
                    end
                end
            end
            NORM:    w_next = r_m[WW-1] ? ROUND : NORM;
            ROUND:   w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        valid_o  = (r_state == DONE);
        busy_o   = (r_state != IDLE);
        result_o = r_result;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_m      <= '0;
            r_s      <= 1'b0;
            r_cnt    <= '0;
            r_result <= 16'h0000;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (valid_i) begin
                        r_s   <= w_w[WW-1];
                        r_m   <= w_mag;
                        r_cnt <= '0;
                        if (w_special) begin
                            r_result <= w_spec_val;
                        end else if (w_mag_zero) begin
                            r_result <= 16'h0000;
                        end
                    end
                end
                NORM: begin
                    if (!r_m[WW-1]) begin
                        r_m   <= r_m << 1;
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ROUND: begin
                    r_result <= {r_s, w_exp_f, w_sum[6:0]};
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flog_pack.sv
// tb_flog_pack: directed vectors with a queue-based scoreboard; a monitor
// pops one expectation per valid_o pulse and checks result and latency.
module tb_flog_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [7:0]  exp_i;
    logic [15:0] frac_i;
    logic        is_nan_i;
    logic        is_inf_i;
    logic        is_zero_i;
    logic        is_neg_i;
    logic [15:0] result_o;
    logic        valid_o;
    logic        busy_o;

    flog_pack #(.FRAC_W(16), .INT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (valid_i),
        .exp_i    (exp_i),
        .frac_i   (frac_i),
        .is_nan_i (is_nan_i),
        .is_inf_i (is_inf_i),
        .is_zero_i(is_zero_i),
        .is_neg_i (is_neg_i),
        .result_o (result_o),
        .valid_o  (valid_o),
        .busy_o   (busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] res;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   n_pass = 0;
    int   n_tot  = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_tot++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", nm, act, req);
    endtask

    // Monitor: every valid_o pulse must match the oldest expectation
    always @(negedge clk) begin
        if (valid_o) begin
            if (sbq.size() == 0) begin
                n_tot++;
                $display("FAIL unexpected_valid: got result %h, want no pulse",
                         result_o);
            end else begin
                e = sbq.pop_front();
                chk({e.name, "_res"}, 32'(result_o), 32'(e.res));
                chk({e.name, "_lat"}, 32'(cyc - e.acc + 1), 32'(e.lat));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy_o) begin
            n_tot++;
            $display("FAIL idle_timeout: got busy_o=1, want 0");
        end
    endtask

    // fl = {nan, inf, zero, neg}
    task automatic issue(input logic [7:0] ex, input logic [15:0] fr,
                         input logic [3:0] fl, input logic [15:0] res,
                         input int lat, input bit push, input string nm);
        wait_idle();
        exp_i     = ex;
        frac_i    = fr;
        is_nan_i  = fl[3];
        is_inf_i  = fl[2];
        is_zero_i = fl[1];
        is_neg_i  = fl[0];
        valid_i   = 1'b1;
        if (push) sbq.push_back('{res, lat, cyc + 1, nm});
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        valid_i   = 1'b0;
        exp_i     = 8'd0;
        frac_i    = 16'd0;
        is_nan_i  = 1'b0;
        is_inf_i  = 1'b0;
        is_zero_i = 1'b0;
        is_neg_i  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", 32'(result_o), 32'h0);
        chk("rst_valid",  32'(valid_o),  32'h0);
        chk("rst_busy",   32'(busy_o),   32'h0);
        rst = 1'b1;
        @(posedge clk); #1;

        issue(8'd127, 16'h0000, 4'b0000, 16'h0000, 1,  1, "log1");
        issue(8'd128, 16'h0000, 4'b0000, 16'h3F80, 10, 1, "log2");
        issue(8'd126, 16'h0000, 4'b0000, 16'hBF80, 10, 1, "log_half");
        issue(8'd128, 16'h95BF, 4'b0000, 16'h3FCB, 10, 1, "log3");
        issue(8'd128, 16'h0100, 4'b0000, 16'h3F80, 10, 1, "tie_down");
        issue(8'd128, 16'h0300, 4'b0000, 16'h3F82, 10, 1, "tie_up");
        issue(8'd254, 16'hFFFF, 4'b0000, 16'h4300, 4,  1, "carry");
        issue(8'd1,   16'h0000, 4'b0000, 16'hC2FC, 4,  1, "minexp");
        issue(8'd127, 16'h0001, 4'b0000, 16'h3780, 26, 1, "tiny");
        issue(8'd100, 16'h1234, 4'b0010, 16'hFF80, 1,  1, "zero");
        issue(8'd128, 16'h0000, 4'b0001, 16'h7FC0, 1,  1, "neg");
        issue(8'd128, 16'h0000, 4'b0100, 16'h7F80, 1,  1, "inf");
        issue(8'd128, 16'h0000, 4'b1000, 16'h7FC0, 1,  1, "nan");
        issue(8'd0,   16'h4000, 4'b0000, 16'hFF80, 1,  1, "exp0");
        issue(8'd255, 16'h4000, 4'b0000, 16'h7F80, 1,  1, "exp255");
        issue(8'd0,   16'h0000, 4'b0011, 16'hFF80, 1,  1, "negzero");
        issue(8'd0,   16'h0000, 4'b1010, 16'h7FC0, 1,  1, "nan_prio");

        // Request during the DONE cycle must be dropped
        issue(8'd128, 16'h0000, 4'b0010, 16'hFF80, 1,  1, "pre_done");
        is_inf_i = 1'b1;
        valid_i  = 1'b1;
        @(posedge clk); #1;
        valid_i  = 1'b0;
        is_inf_i = 1'b0;
        chk("done_drop_busy", 32'(busy_o), 32'h0);

        // Request while busy must be dropped
        issue(8'd127, 16'h0001, 4'b0000, 16'h3780, 26, 1, "long");
        repeat (3) @(posedge clk);
        #1;
        is_nan_i = 1'b1;
        valid_i  = 1'b1;
        @(posedge clk); #1;
        valid_i  = 1'b0;
        is_nan_i = 1'b0;

        // Reset in NORM aborts with no pulse and clears result
        issue(8'd128, 16'h0000, 4'b0000, 16'h3F80, 10, 0, "aborted");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_busy",   32'(busy_o),   32'h0);
        chk("mid_rst_valid",  32'(valid_o),  32'h0);
        chk("mid_rst_result", 32'(result_o), 32'h0);
        rst = 1'b1;
        issue(8'd126, 16'h0000, 4'b0000, 16'hBF80, 10, 1, "post_rst");

        wait_idle();
        repeat (20) @(posedge clk);
        #1;
        chk("queue_empty", 32'(sbq.size()), 32'h0);
        chk("hold_result", 32'(result_o), 32'hBF80);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
